keypad_emulator: RTL and testbench

//  Emulates a 4x4 passive keypad matrix for loopback self-test of the scanner path.

---
 rtl/keypad_emulator.sv | 126 ++++++++++++
 tb/tb_keypad_emulator.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_emulator.sv
// keypad_emulator: 4x4 passive keypad for scanner loopback; cols is combinational from rows and contact state.
// Latency: a command runs 2*BOUNCE_CYCLES+max(hold,1)+GAP_CYCLES cycles; cmd_ready stays low until done.
// KEYPAD_EMU_BOUNCE_EN enables LFSR contact chatter; otherwise each bounce phase is a single clean cycle.
module keypad_emulator #(
    parameter int          BOUNCE_CYCLES = 64,
    parameter int          GAP_CYCLES    = 256,
    parameter int          HOLD_W        = 16,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        rows,
    output logic [3:0]        cols,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_key,
    input  logic [HOLD_W-1:0] cmd_hold,
    output logic              busy,
    output logic              done,
    output logic              contact
);
    localparam int BNC_W  = $clog2(BOUNCE_CYCLES + 1);
    localparam int GAP_W  = $clog2(GAP_CYCLES + 1);
    localparam int CNT_W0 = (BNC_W > GAP_W) ? BNC_W : GAP_W;
    localparam int CNT_W  = (CNT_W0 > HOLD_W) ? CNT_W0 : HOLD_W;
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, B_PRESS, HOLD, B_REL, GAP} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  hold_load;
    logic [3:0]        key_q;
    logic [HOLD_W-1:0] hold_q;
    logic              accept, cnt_zero, chatter;

`ifdef KEYPAD_EMU_BOUNCE_EN
    localparam logic [CNT_W-1:0] BOUNCE_LOAD = CNT_W'(BOUNCE_CYCLES - 1);
    logic [15:0] lfsr_q;

    // Fibonacci taps 16,14,13,11; only steps while a bounce phase is active.
    always_ff @(posedge clk) begin
        if (reset)
            lfsr_q <= LFSR_SEED;
        else if (state_q == B_PRESS || state_q == B_REL)
            lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
    assign chatter = lfsr_q[0];
`else
    localparam logic [CNT_W-1:0] BOUNCE_LOAD = '0;
    // Bounce phases are one cycle here, so their forced end value is all that is ever seen.
    assign chatter = 1'b0 & (|LFSR_SEED);
`endif

    assign cmd_ready = (state_q == IDLE);
    assign busy      = ~cmd_ready;
    assign accept    = cmd_valid && cmd_ready;
    assign cnt_zero  = (cnt_q == '0);
    assign hold_load = (hold_q == '0) ? '0 : CNT_W'(hold_q) - 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            key_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                key_q  <= cmd_key;
                hold_q <= cmd_hold;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_zero ? cnt_q : cnt_q - 1'b1;
        contact = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = B_PRESS;
                    cnt_d   = BOUNCE_LOAD;
                end
            end
            B_PRESS: begin
                contact = cnt_zero | chatter;
                if (cnt_zero) begin
                    state_d = HOLD;
                    cnt_d   = hold_load;
                end
            end
            HOLD: begin
                contact = 1'b1;
                if (cnt_zero) begin
                    state_d = B_REL;
                    cnt_d   = BOUNCE_LOAD;
                end
            end
            B_REL: begin
                contact = ~cnt_zero & chatter;
                if (cnt_zero) begin
                    state_d = GAP;
                    cnt_d   = GAP_LOAD;
                end
            end
            GAP: begin
                if (cnt_zero) begin
                    state_d = IDLE;
                    // An abort landing on the final gap cycle must not report completion.
                    done    = ~reset;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cols = 4'b1111;
        if (contact && !rows[key_q[3:2]])
            cols[key_q[1:0]] = 1'b0;
    end
endmodule

// File: tb/tb_keypad_emulator.sv
// Bench for keypad_emulator: phase-timeline model checked every cycle plus directed literal checks.
`timescale 1ns/1ps
module tb_keypad_emulator;
`ifdef KEYPAD_EMU_BOUNCE_EN
    localparam bit BNC = 1'b1;
`else
    localparam bit BNC = 1'b0;
`endif
    localparam int          PB   = BNC ? 64 : 1;
    localparam int          G    = 256;
    localparam logic [15:0] SEED = 16'hACE1;

    logic        clk, reset, cmd_valid, cmd_ready, busy, done, contact;
    logic [3:0]  rows, cols, cmd_key;
    logic [15:0] cmd_hold;

    keypad_emulator dut (
        .clk(clk), .reset(reset), .rows(rows), .cols(cols),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_key(cmd_key), .cmd_hold(cmd_hold),
        .busy(busy), .done(done), .contact(contact)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int acc_cyc = -1;
    int done_cyc = -1;
    int ndone = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: a command is a timeline of phases indexed by n = cycles since acceptance.
    bit          armed = 1'b0;
    bit          m_busy = 1'b0;
    int          m_n = 0;
    int          m_hold = 0;
    logic [3:0]  m_key = 4'h0;
    logic [15:0] m_lfsr = SEED;

    function automatic int eff_hold(input int h);
        return (h < 1) ? 1 : h;
    endfunction

    function automatic int total_len(input int h);
        return 2 * PB + eff_hold(h) + G;
    endfunction

    function automatic bit in_bounce(input int n, input int h);
        return (n <= PB) || (n > PB + eff_hold(h) && n <= 2 * PB + eff_hold(h));
    endfunction

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    function automatic logic exp_contact();
        int h;
        h = eff_hold(m_hold);
        if (!m_busy)                 return 1'b0;
        if (m_n < PB)                return m_lfsr[0];
        if (m_n <= PB + h)           return 1'b1;
        if (m_n < 2 * PB + h)        return m_lfsr[0];
        return 1'b0;
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            m_busy = 1'b0;
            m_n    = 0;
            m_lfsr = SEED;
            armed  = 1'b1;
        end else if (!m_busy) begin
            if (cmd_valid) begin
                m_busy = 1'b1;
                m_n    = 1;
                m_key  = cmd_key;
                m_hold = int'(cmd_hold);
            end
        end else begin
            if (BNC && in_bounce(m_n, m_hold)) m_lfsr = lfsr_step(m_lfsr);
            if (m_n == total_len(m_hold)) m_busy = 1'b0;
            else m_n++;
        end
    end

    always @(negedge clk) begin
        logic       ec;
        logic [3:0] ecols;
        if (armed) begin
            ec    = exp_contact();
            ecols = 4'b1111;
            if (ec && !rows[m_key[3:2]]) ecols[m_key[1:0]] = 1'b0;
            chk("m_ready",   cmd_ready, !m_busy);
            chk("m_busy",    busy, m_busy);
            chk("m_done",    done, m_busy && m_n == total_len(m_hold) && !reset);
            chk("m_contact", contact, ec);
            chk("m_cols",    cols, ecols);
            if (!reset && cmd_valid && cmd_ready) acc_cyc = cyc;
            if (done) begin
                done_cyc = cyc;
                ndone++;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] key, input logic [15:0] hold);
        int   budget;
        logic r;
        budget = 3000;
        cmd_valid = 1'b1;
        cmd_key   = key;
        cmd_hold  = hold;
        do begin
            @(negedge clk);
            r = cmd_ready;
            @(posedge clk);
            #1;
            budget--;
        end while (!r && budget > 0);
        if (!r) chk("accept_timeout", 32'd0, 32'd1);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done();
        int budget;
        budget = 3000;
        do begin
            @(negedge clk);
            budget--;
        end while (!done && budget > 0);
        if (!done) chk("done_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int nd;
        reset = 1'b1; rows = 4'hF; cmd_valid = 1'b0; cmd_key = 4'h0; cmd_hold = 16'd0;
        step(3);
        @(negedge clk);
        chk("rst_cols", cols, 4'b1111);
        chk("rst_ready", cmd_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        step(1);
        reset = 1'b0;

        // Row sweep during the stable hold of key 6 (row 1, col 2).
        send(4'h6, 16'd1000);
        step(PB + 10);
        for (int i = 0; i < 4; i++) begin
            rows = ~(4'b0001 << i);
            @(negedge clk);
            chk("sweep_cols", cols, (i == 1) ? 4'b1011 : 4'b1111);
            step(1);
        end
        rows = 4'hF;
        wait_done();

        // Command length from acceptance to done.
        rows = 4'h0;
        send(4'h0, 16'd10);
        wait_done();
        chk("cmd_length", done_cyc - acc_cyc, BNC ? 32'd394 : 32'd268);

        // Second command held on the port while busy is taken right after done.
        send(4'h3, 16'd5);
        send(4'h9, 16'd2);
        chk("accept_after_done", acc_cyc - done_cyc, 32'd1);
        wait_done();

        // Zero hold: clean edges at the end of each bounce phase.
        send(4'hA, 16'd0);
        step(PB - 1);
        @(negedge clk);
        chk("last_press_contact", contact, 1'b1);
        step(1);
        @(negedge clk);
        chk("hold0_contact", contact, 1'b1);
        step(PB);
        @(negedge clk);
        chk("last_rel_contact", contact, 1'b0);
        chk("last_rel_busy", busy, 1'b1);
        wait_done();

        // All rows driven low with key F.
        send(4'hF, 16'd20);
        step(PB + 3);
        @(negedge clk);
        chk("allrows_cols", cols, 4'b0111);
        wait_done();

        // Reset held mid-hold aborts without a done pulse.
        send(4'h5, 16'd500);
        step(PB + 20);
        @(negedge clk);
        chk("pre_abort_busy", busy, 1'b1);
        nd = ndone;
        step(1);
        reset = 1'b1;
        step(1);
        @(negedge clk);
        chk("abort_cols", cols, 4'b1111);
        chk("abort_ready", cmd_ready, 1'b1);
        chk("abort_busy", busy, 1'b0);
        chk("abort_contact", contact, 1'b0);
        step(2);
        reset = 1'b0;
        step(600);
        chk("abort_no_done", ndone, nd);

        send(4'hC, 16'd3);
        wait_done();
        chk("post_abort_length", done_cyc - acc_cyc, total_len(3));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
